ex_result_buffer: RTL and testbench
===================================

Name: ex_result_buffer

Overview:
- Receiving end of the EX-stage result interface.
- Accepts the EX write-back triple (wd, wreg, wdata) under a valid/ready handshake and holds it in a small in-order buffer.
- Presents the oldest entry to the MEM/write-back side, with its own valid/ready handshake.
- Serves combinational forwarding lookups to the ID stage from every buffered entry, so the pipeline can stall downstream without losing or hiding EX results.

Parameters:
- DATA_W, 32, register data width (RegBus).
- ADDR_W, 5, register address width (RegAddrBus).
- DEPTH, 2, number of buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high (RstEnable).
- flush_i  in  1  synchronous discard of all buffered entries.
- in_valid_i  in  1  EX presents a result this cycle.
- in_ready_o  out  1  buffer can accept a result this cycle.
- in_wd_i  in  ADDR_W  destination register from EX.
- in_wreg_i  in  1  write enable from EX (already cleared by EX on ADD overflow).
- in_wdata_i  in  DATA_W  result data from EX.
- out_valid_o  out  1  head entry is valid.
- out_ready_i  in  1  MEM side consumes the head this cycle.
- out_wd_o  out  ADDR_W  head destination register.
- out_wreg_o  out  1  head write enable.
- out_wdata_o  out  DATA_W  head data.
- fwd_addr0_i, fwd_addr1_i  in  ADDR_W  ID read-port addresses.
- fwd_hit0_o, fwd_hit1_o  out  1  buffered result matches the address.
- fwd_data0_o, fwd_data1_o  out  DATA_W  forwarded data.
- count_o  out  clog2(DEPTH)+1  occupancy.

Behaviour:
- **Storage:** circular buffer with wr_ptr, rd_ptr and count registers; each entry holds {wd, wreg, wdata}.
- **Push:** occurs when in_valid_i && in_ready_o. in_ready_o = (count < DEPTH), purely from registered state. There is no same-cycle pass-through when full, even if out_ready_i = 1.
- **Pop:** occurs when out_valid_o && out_ready_i. out_valid_o = (count != 0).
- **Simultaneous push and pop** (count between 1 and DEPTH-1, or count = 0 with pop impossible): both pointers advance and count is unchanged.
- **Latency:** a pushed entry appears on out_* on the next cycle at the earliest.
- **Pointer wrap:** pointers wrap modulo DEPTH.
- **Empty outputs:** while empty, out_wd_o = 0, out_wreg_o = 0 (WriteDisable) and out_wdata_o = 0 (ZeroWord). Otherwise out_* show the head entry combinationally from storage.
- **Flush:** flush_i sets count, wr_ptr and rd_ptr to 0 next cycle. Flush takes precedence over a same-cycle push or pop, so a concurrent push is dropped. in_ready_o is unaffected by flush_i in the flush cycle.
- **Reset:** rst takes precedence over flush_i. Pointers and count are cleared. All outputs go to 0 next cycle, except in_ready_o, which is 1. Entry payloads are not cleared. Reset mid-stream discards all entries.
- **Forwarding, per port n:** hit when an occupied entry has wreg = 1 and wd == fwd_addrn_i, with fwd_addrn_i != 0.
  - The youngest matching entry wins (closest to wr_ptr).
  - On a miss: hit = 0, data = 0.
  - Entries with wreg = 0 never match, including overflow-suppressed ADD results.
  - The current-cycle EX input is not searched; EX-to-ID forwarding stays in ID.
- **Payload:** wd = 0 with wreg = 1 is stored and passed through unchanged; the register file ignores writes to $0.
- **Errors:** no overflow or underflow is possible. Pushes while full and pops while empty are ignored.

Decomposition:
- The shared defines file (defines.v) carries RstEnable, ZeroWord, WriteEnable/WriteDisable, RegBus and RegAddrBus; the module uses these, with no local literals.
- One natural sub-module: fwd_match (combinational youngest-match priority search over DEPTH entries), instantiated once per forwarding port.
- Buffer control (pointers, count) stays in the top module.

Test Plan:
- Reset, then push {wd=3, wreg=1, wdata=0x0000_00AA} with out_ready=1 → out_valid=1 next cycle showing wd=3, data 0xAA; count 1→0 after the pop.
- out_ready=0, push three results (wd=1, 2, 3) → third push stalls with in_ready=0, count=2. Then out_ready=1 → wd=1 then wd=2 pop in order, and wd=3 is accepted the cycle after in_ready rises.
- Buffer holds wd=5 data 0x11 (older) and wd=5 data 0x22 (younger); fwd_addr0=5, fwd_addr1=0 → hit0=1 with data 0x22; hit1=0 with data 0.
- Entry {wd=7, wreg=0, data 0xFFFF_FFFF} (overflow case), fwd_addr0=7 → hit0=0; the entry still pops with out_wreg=0.
- count=1, flush_i=1 with a simultaneous valid push → next cycle count=0, out_valid=0, all out_* 0.
- count=2, rst=1 together with flush_i and out_ready → next cycle count=0, in_ready=1; after rst deasserts, the next push of wd=9 emerges as the head.

Source files
------------

// File: rtl/ex_result_buffer_pkg.sv
// ex_result_buffer_pkg: shared pipeline constants for the EX result buffer slice
package ex_result_buffer_pkg;
  localparam int REG_BUS_W = 32;
  localparam int REG_ADDR_BUS_W = 5;
  localparam logic RST_ENABLE = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic [REG_BUS_W-1:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [REG_ADDR_BUS_W-1:0] ZERO_ADDR = 5'd0;
endpackage

// File: rtl/ex_result_buffer_fwd_match.sv
// ex_result_buffer_fwd_match: youngest-first register match over the occupied buffer entries
module ex_result_buffer_fwd_match
  import ex_result_buffer_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_BUS_W,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [PW-1:0]     wr_ptr,
  input  logic [CW-1:0]     count,
  input  logic [ADDR_W-1:0] wd [DEPTH],
  input  logic [DEPTH-1:0]  wreg,
  input  logic [DATA_W-1:0] wdata [DEPTH],
  output logic              hit,
  output logic [DATA_W-1:0] data
);
  logic [PW-1:0] idx;
  // Walk oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit = 1'b0;
    data = DATA_W'(ZERO_WORD);
    idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = wr_ptr - PW'(k + 1);
      if (CW'(k) < count && wreg[idx] == WRITE_ENABLE && wd[idx] == addr && addr != ADDR_W'(ZERO_ADDR)) begin
        hit = 1'b1;
        data = wdata[idx];
      end
    end
  end
endmodule

// File: rtl/ex_result_buffer.sv
// ex_result_buffer: in-order EX write-back buffer with valid/ready on both sides and ID forwarding
module ex_result_buffer
  import ex_result_buffer_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_BUS_W,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_wd_i,
  input  logic              in_wreg_i,
  input  logic [DATA_W-1:0] in_wdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_wd_o,
  output logic              out_wreg_o,
  output logic [DATA_W-1:0] out_wdata_o,
  input  logic [ADDR_W-1:0] fwd_addr0_i,
  input  logic [ADDR_W-1:0] fwd_addr1_i,
  output logic              fwd_hit0_o,
  output logic              fwd_hit1_o,
  output logic [DATA_W-1:0] fwd_data0_o,
  output logic [DATA_W-1:0] fwd_data1_o,
  output logic [CW-1:0]     count_o
);
  logic [ADDR_W-1:0] mem_wd [DEPTH];
  logic [DEPTH-1:0]  mem_wreg;
  logic [DATA_W-1:0] mem_wdata [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              push, pop;

  assign in_ready_o = count < CW'(DEPTH);
  assign out_valid_o = count != '0;
  assign push = in_valid_i && in_ready_o;
  assign pop = out_valid_o && out_ready_i;
  assign count_o = count;
  assign out_wd_o = out_valid_o ? mem_wd[rd_ptr] : ADDR_W'(ZERO_ADDR);
  assign out_wreg_o = out_valid_o ? mem_wreg[rd_ptr] : WRITE_DISABLE;
  assign out_wdata_o = out_valid_o ? mem_wdata[rd_ptr] : DATA_W'(ZERO_WORD);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload is left out of reset; only occupied slots are ever observed.
  always_ff @(posedge clk) begin
    if (push && !flush_i) begin
      mem_wd[wr_ptr] <= in_wd_i;
      mem_wreg[wr_ptr] <= in_wreg_i;
      mem_wdata[wr_ptr] <= in_wdata_i;
    end
  end

  ex_result_buffer_fwd_match #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fwd0 (
    .addr(fwd_addr0_i), .wr_ptr(wr_ptr), .count(count), .wd(mem_wd), .wreg(mem_wreg),
    .wdata(mem_wdata), .hit(fwd_hit0_o), .data(fwd_data0_o)
  );

  ex_result_buffer_fwd_match #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fwd1 (
    .addr(fwd_addr1_i), .wr_ptr(wr_ptr), .count(count), .wd(mem_wd), .wreg(mem_wreg),
    .wdata(mem_wdata), .hit(fwd_hit1_o), .data(fwd_data1_o)
  );
endmodule

// File: tb/tb_ex_result_buffer.sv
// tb_ex_result_buffer: scoreboard bench for the EX result buffer
module tb_ex_result_buffer;
  localparam int DEPTH = 2;
  typedef struct {logic [4:0] wd; logic wreg; logic [31:0] data;} ent_t;

  logic clk = 1'b0;
  logic rst, flush_i, in_valid_i, in_ready_o, in_wreg_i, out_valid_o, out_ready_i, out_wreg_o;
  logic fwd_hit0_o, fwd_hit1_o;
  logic [4:0] in_wd_i, out_wd_o, fwd_addr0_i, fwd_addr1_i;
  logic [31:0] in_wdata_i, out_wdata_o, fwd_data0_o, fwd_data1_o;
  logic [1:0] count_o;
  ent_t q[$];
  int n_vec = 0;
  int n_err = 0;

  ex_result_buffer #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_wd_i(in_wd_i), .in_wreg_i(in_wreg_i), .in_wdata_i(in_wdata_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_wd_o(out_wd_o), .out_wreg_o(out_wreg_o), .out_wdata_o(out_wdata_o),
    .fwd_addr0_i(fwd_addr0_i), .fwd_addr1_i(fwd_addr1_i), .fwd_hit0_o(fwd_hit0_o), .fwd_hit1_o(fwd_hit1_o),
    .fwd_data0_o(fwd_data0_o), .fwd_data1_o(fwd_data1_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  function automatic void exp_fwd(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (a != 5'd0)
      for (int i = 0; i < q.size(); i++)
        if (q[i].wreg && q[i].wd == a) begin
          h = 1'b1;
          d = q[i].data;
        end
  endfunction

  task automatic drive(input logic v, input logic [4:0] wd, input logic wreg, input logic [31:0] data);
    in_valid_i = v;
    in_wd_i = wd;
    in_wreg_i = wreg;
    in_wdata_i = data;
  endtask

  // Compare the DUT against the model, then advance the model across one clock edge.
  task automatic tick();
    ent_t e;
    int n;
    logic h;
    logic [31:0] d;
    #1;
    n = q.size();
    e = n != 0 ? q[0] : '{5'd0, 1'b0, 32'd0};
    n_vec += 8;
    if (count_o !== 2'(n)) begin n_err++; $display("FAIL count: got %0d want %0d", count_o, n); end
    if (in_ready_o !== (n < DEPTH)) begin n_err++; $display("FAIL in_ready: got %b want %b", in_ready_o, n < DEPTH); end
    if (out_valid_o !== (n != 0)) begin n_err++; $display("FAIL out_valid: got %b want %b", out_valid_o, n != 0); end
    if (out_wd_o !== e.wd) begin n_err++; $display("FAIL out_wd: got %0d want %0d", out_wd_o, e.wd); end
    if (out_wreg_o !== e.wreg) begin n_err++; $display("FAIL out_wreg: got %b want %b", out_wreg_o, e.wreg); end
    if (out_wdata_o !== e.data) begin n_err++; $display("FAIL out_wdata: got %h want %h", out_wdata_o, e.data); end
    exp_fwd(fwd_addr0_i, h, d);
    if (fwd_hit0_o !== h || fwd_data0_o !== d) begin n_err++; $display("FAIL fwd0: got %b/%h want %b/%h", fwd_hit0_o, fwd_data0_o, h, d); end
    exp_fwd(fwd_addr1_i, h, d);
    if (fwd_hit1_o !== h || fwd_data1_o !== d) begin n_err++; $display("FAIL fwd1: got %b/%h want %b/%h", fwd_hit1_o, fwd_data1_o, h, d); end
    if (rst || flush_i) q.delete();
    else begin
      if (out_ready_i && n != 0) void'(q.pop_front());
      if (in_valid_i && n < DEPTH) q.push_back('{in_wd_i, in_wreg_i, in_wdata_i});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush_i = 1'b0;
    out_ready_i = 1'b0;
    fwd_addr0_i = 5'd0;
    fwd_addr1_i = 5'd0;
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (count_o !== 2'd0 || in_ready_o !== 1'b1 || out_valid_o !== 1'b0)
      begin n_err++; $display("FAIL reset: got cnt=%0d rdy=%b vld=%b want 0/1/0", count_o, in_ready_o, out_valid_o); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    out_ready_i = 1'b1;
    drive(1'b1, 5'd3, 1'b1, 32'h0000_00AA);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    n_vec++;
    if (out_valid_o !== 1'b1 || out_wd_o !== 5'd3 || out_wdata_o !== 32'hAA || count_o !== 2'd1)
      begin n_err++; $display("FAIL basic_head: got v=%b wd=%0d d=%h c=%0d want 1/3/aa/1", out_valid_o, out_wd_o, out_wdata_o, count_o); end
    tick();
    n_vec++;
    if (count_o !== 2'd0) begin n_err++; $display("FAIL basic_drain: got %0d want 0", count_o); end
  endtask

  task automatic test_stall();
    out_ready_i = 1'b0;
    drive(1'b1, 5'd1, 1'b1, 32'h101);
    tick();
    drive(1'b1, 5'd2, 1'b1, 32'h202);
    tick();
    drive(1'b1, 5'd3, 1'b1, 32'h303);
    n_vec++;
    if (in_ready_o !== 1'b0 || count_o !== 2'd2) begin n_err++; $display("FAIL stall_full: got rdy=%b c=%0d want 0/2", in_ready_o, count_o); end
    tick();
    out_ready_i = 1'b1;
    tick();
    n_vec++;
    if (out_wd_o !== 5'd2 || in_ready_o !== 1'b1) begin n_err++; $display("FAIL stall_order: got wd=%0d rdy=%b want 2/1", out_wd_o, in_ready_o); end
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    n_vec++;
    if (out_wd_o !== 5'd3) begin n_err++; $display("FAIL stall_late: got wd=%0d want 3", out_wd_o); end
    tick();
  endtask

  task automatic test_fwd();
    out_ready_i = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 32'h11);
    tick();
    drive(1'b1, 5'd5, 1'b1, 32'h22);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    fwd_addr0_i = 5'd5;
    fwd_addr1_i = 5'd0;
    #1;
    n_vec += 2;
    if (fwd_hit0_o !== 1'b1 || fwd_data0_o !== 32'h22) begin n_err++; $display("FAIL fwd_young: got %b/%h want 1/22", fwd_hit0_o, fwd_data0_o); end
    if (fwd_hit1_o !== 1'b0 || fwd_data1_o !== 32'h0) begin n_err++; $display("FAIL fwd_zero: got %b/%h want 0/0", fwd_hit1_o, fwd_data1_o); end
    out_ready_i = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_overflow();
    out_ready_i = 1'b0;
    fwd_addr0_i = 5'd7;
    drive(1'b1, 5'd7, 1'b0, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    out_ready_i = 1'b1;
    #1;
    n_vec++;
    if (fwd_hit0_o !== 1'b0 || out_valid_o !== 1'b1 || out_wreg_o !== 1'b0)
      begin n_err++; $display("FAIL ovf: got hit=%b v=%b wreg=%b want 0/1/0", fwd_hit0_o, out_valid_o, out_wreg_o); end
    tick();
  endtask

  task automatic test_flush();
    out_ready_i = 1'b0;
    drive(1'b1, 5'd4, 1'b1, 32'h44);
    tick();
    flush_i = 1'b1;
    drive(1'b1, 5'd6, 1'b1, 32'h66);
    tick();
    flush_i = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    n_vec++;
    if (count_o !== 2'd0 || out_valid_o !== 1'b0 || out_wd_o !== 5'd0 || out_wreg_o !== 1'b0 || out_wdata_o !== 32'd0)
      begin n_err++; $display("FAIL flush: got c=%0d v=%b wd=%0d w=%b d=%h want all 0", count_o, out_valid_o, out_wd_o, out_wreg_o, out_wdata_o); end
    tick();
  endtask

  task automatic test_rst_mid();
    out_ready_i = 1'b0;
    drive(1'b1, 5'd8, 1'b1, 32'h88);
    tick();
    drive(1'b1, 5'd10, 1'b1, 32'hA0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    rst = 1'b1;
    flush_i = 1'b1;
    out_ready_i = 1'b1;
    tick();
    rst = 1'b0;
    flush_i = 1'b0;
    out_ready_i = 1'b0;
    n_vec++;
    if (count_o !== 2'd0 || in_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_mid: got c=%0d rdy=%b want 0/1", count_o, in_ready_o); end
    drive(1'b1, 5'd9, 1'b1, 32'h99);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    n_vec++;
    if (out_wd_o !== 5'd9 || out_valid_o !== 1'b1) begin n_err++; $display("FAIL rst_head: got wd=%0d v=%b want 9/1", out_wd_o, out_valid_o); end
    out_ready_i = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
      out_ready_i = 1'($urandom_range(0, 1));
      flush_i = $urandom_range(0, 15) == 0;
      fwd_addr0_i = 5'($urandom_range(0, 3));
      fwd_addr1_i = 5'($urandom_range(0, 3));
      tick();
    end
    flush_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_fwd();
    test_overflow();
    test_flush();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
